// File: rtl/relay_arb_pkg.sv
// ---------------------------------------------------------------------------
// relay_arb_pkg
//   Shared types and helpers for the relay_station write-side arbiter.
//   - arb_state_e : two-state grant FSM encoding (IDLE / HOLD).
//   - idx_width() : bit width needed to index n items, never below one bit,
//                   so single-requester builds still have a legal tag field.
// ---------------------------------------------------------------------------
package relay_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Index width for n items; a one-item set still gets a one-bit field.
  function automatic int idx_width(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/relay_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating priority encoder. Scans req starting at slot ptr,
//   then ptr+1, ... wrapping modulo N, and reports the first requesting slot.
//   Kept free of any write-side detail so read-side arbiters can reuse it.
//
// Ports
//   req   : input  [N-1:0]  request vector, one bit per slot
//   ptr   : input  [IW-1:0] slot with highest priority this cycle (< N)
//   found : output          at least one request is present
//   idx   : output [IW-1:0] winning slot (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick
  import relay_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk the N slots in rotated order; the first hit wins and later hits are ignored.
  always_comb begin
    int          cand;
    logic [IW-1:0] cand_idx;
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand     = (int'(ptr) + off) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/relay_write_arbiter.sv
// ---------------------------------------------------------------------------
// relay_write_arbiter
//   Round-robin arbiter that shares one relay_station write port among
//   NUM_REQ producers using the FIFO write handshake (full_n / write / din).
//   A grant is held for up to MAX_BURST accepted beats; every accepted word is
//   tagged with its source index and parked in a registered output stage that
//   drives the relay station's write side. One IDLE cycle always separates
//   consecutive grants (arbitration bubble), even for the same requester.
//
// Ports
//   clk         : input                         clock
//   reset       : input                         asynchronous active-high reset
//   in_full_n   : output [NUM_REQ-1:0]          per-requester ready (comb. from out_full_n)
//   in_write    : input  [NUM_REQ-1:0]          per-requester write request
//   in_din      : input  [NUM_REQ*DATA_WIDTH-1:0] payloads, requester i at [i*DW +: DW]
//   out_full_n  : input                         relay station if_full_n
//   out_write   : output                        relay station if_write (registered)
//   out_din     : output [TAG_WIDTH+DATA_WIDTH-1:0] {tag, payload} (registered)
//   grant_valid : output                        a requester holds the grant
//   grant_idx   : output [TAG_WIDTH-1:0]        current / most recent grant holder
// ---------------------------------------------------------------------------
module relay_write_arbiter
  import relay_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 8,
  localparam int TAG_WIDTH  = idx_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [NUM_REQ-1:0]              in_full_n,
  input  logic [NUM_REQ-1:0]              in_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_din,
  input  logic                            out_full_n,
  output logic                            out_write,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
  output logic                            grant_valid,
  output logic [TAG_WIDTH-1:0]            grant_idx
);

  localparam int                   CNT_WIDTH = idx_width(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [TAG_WIDTH-1:0] LAST_IDX  = TAG_WIDTH'(NUM_REQ - 1);

  // FSM and datapath state
  arb_state_e                      state_q,     state_d;
  logic [TAG_WIDTH-1:0]            rr_ptr_q,    rr_ptr_d;
  logic [CNT_WIDTH-1:0]            burst_cnt_q, burst_cnt_d;
  logic [TAG_WIDTH-1:0]            grant_idx_q, grant_idx_d;
  logic                            out_write_q, out_write_d;
  logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din_q,   out_din_d;

  // Combinational helpers
  logic                  can_load;
  logic                  gnt_write;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  accept;
  logic                  pick_found;
  logic [TAG_WIDTH-1:0]  pick_idx;
  logic [TAG_WIDTH-1:0]  next_ptr;

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (in_write),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Route the grant holder's request and payload onto shared wires.
  always_comb begin
    gnt_write = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_write = (grant_idx_q == TAG_WIDTH'(i)) ? in_write[i] : gnt_write;
      gnt_data  = (grant_idx_q == TAG_WIDTH'(i)) ? in_din[i*DATA_WIDTH +: DATA_WIDTH] : gnt_data;
    end
  end

  // Handshake terms: the output slot can take a word if empty or draining now.
  always_comb begin
    can_load = !out_write_q || out_full_n;
    accept   = (state_q == HOLD) && gnt_write && can_load;
    if (grant_idx_q == LAST_IDX) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx_q + TAG_WIDTH'(1);
    end
  end

  // State register, including the inline output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_idx_q <= '0;
      out_write_q <= 1'b0;
      out_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_idx_q <= grant_idx_d;
      out_write_q <= out_write_d;
      out_din_q   <= out_din_d;
    end
  end

  // Next-state logic for the grant FSM and the burst counter.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_idx_d = grant_idx_q;
    case (state_q)
      IDLE: begin
        // Arbitration only; no beat is taken in this cycle.
        if (pick_found) begin
          state_d     = HOLD;
          grant_idx_d = pick_idx;
          burst_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!gnt_write) begin
          // Holder went quiet: release early and rotate past it.
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (accept && (burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
        end else begin
          // Backpressure stall: grant and beat count are frozen.
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next value of the output stage; a load while draining keeps out_write high.
  always_comb begin
    out_write_d = out_write_q;
    out_din_d   = out_din_q;
    if (accept) begin
      out_write_d = 1'b1;
      out_din_d   = {grant_idx_q, gnt_data};
    end else if (out_write_q && out_full_n) begin
      out_write_d = 1'b0;
    end else begin
      out_write_d = out_write_q;
    end
  end

  // FSM outputs: ready goes only to the grant holder, and only when the slot can load.
  always_comb begin
    in_full_n   = '0;
    grant_valid = (state_q == HOLD);
    for (int i = 0; i < NUM_REQ; i++) begin
      in_full_n[i] = (state_q == HOLD) && (grant_idx_q == TAG_WIDTH'(i)) && can_load;
    end
  end

  assign out_write = out_write_q;
  assign out_din   = out_din_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: doc/relay_write_arbiter.md
Name: relay_write_arbiter

Overview:
- Round-robin arbiter sharing one relay_station write port among NUM_REQ producers, each using the FIFO write handshake (full_n/write/din).
- Grants are held for bursts of up to MAX_BURST beats. Each accepted word is tagged with its source index and placed in a registered output stage that drives the relay station's write side.
- Sits between several compute PEs and a single long-haul relay_station channel.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- DATA_WIDTH, 32, payload width per requester.
- MAX_BURST, 8, maximum consecutive beats per grant (>=1).
- TAG_WIDTH, max(1,$clog2(NUM_REQ)), derived (localparam); source-index width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_full_n  output  NUM_REQ  per-requester ready; bit i high means a write on i is accepted this cycle.
- in_write  input  NUM_REQ  per-requester write request/valid.
- in_din  input  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_full_n  input  1  relay station if_full_n.
- out_write  output  1  relay station if_write (registered).
- out_din  output  TAG_WIDTH+DATA_WIDTH  {tag, payload} (registered); tag in MSBs.
- grant_valid  output  1  a requester currently holds the grant (debug).
- grant_idx  output  TAG_WIDTH  index of current grant holder (debug).

Behaviour:
- Reset (async assert, sync release) clears:
  - out_write=0, out_din=0, grant_valid=0, grant_idx=0
  - rr_ptr=0, burst_cnt=0, state=IDLE
  - in_full_n=0 (all bits)
- Output register:
  - can_load = !out_write | out_full_n.
  - A word leaves when out_write & out_full_n.
  - On an accepted input beat, out_din <= {grant_idx, in_din[grant_idx]} and out_write <= 1.
  - Otherwise, if the held word leaves, out_write <= 0.
  - out_din holds its value while out_write=1 and out_full_n=0.
- in_full_n[i] = (state==HOLD) & (grant_idx==i) & can_load. Combinational from out_full_n; all other bits are 0.
- Accept = in_write[grant_idx] & in_full_n[grant_idx].
- State machine:
  - IDLE:
    - If any in_write is high, grant the first index found scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
    - On grant: grant_idx <= winner, burst_cnt <= 0, state <= HOLD.
    - No beat is accepted in IDLE (one-cycle arbitration bubble).
  - HOLD:
    - If in_write[grant_idx]==0: state <= IDLE, rr_ptr <= grant_idx+1 mod NUM_REQ.
    - Else, on accept with burst_cnt==MAX_BURST-1: state <= IDLE, rr_ptr <= grant_idx+1.
    - Else, on accept: burst_cnt++.
    - Backpressure stall (in_write high, can_load low): hold state; burst_cnt is unchanged.
- Latency:
  - Request in IDLE at cycle t: grant at t+1, first beat accepted at t+1, out_write high at t+2.
  - Within a burst: 1 beat/cycle while out_full_n=1.
- Re-grant gap: at least one IDLE cycle between grants, including re-grant to the same requester. A lone requester sustains MAX_BURST/(MAX_BURST+1) throughput.
- Wrap-around: rr_ptr increment wraps NUM_REQ-1 -> 0. With NUM_REQ=1, tag is always 0 and rr_ptr stays 0.
- Fairness: any requester holding in_write high is granted within NUM_REQ-1 other grants.
- Simultaneous events: a word leaving and a new beat loading in the same cycle keep out_write=1 with the new data (no bubble).
- Reset mid-burst: the in-flight output word is dropped and the FSM returns to IDLE. Upstream producers must also be reset.
- grant_valid = (state==HOLD).

Decomposition:
- Package relay_arb_pkg: state encoding (IDLE=1'b0, HOLD=1'b1), tag-width helper function.
- One sub-module, rr_pick: combinational rotating priority encoder (req vector, rr_ptr -> found, idx). Reusable for read-side arbiters.
- Output register stays inline.

Test Plan:
- Single requester, NUM_REQ=4, MAX_BURST=8:
  - Stimulus: in_write[2]=1 continuously, out_full_n=1, data 0..15.
  - Required: out_din tags all 2; data 0..7, one-cycle gap, then 8..15; first out_write at t+2.
- All four requesting, MAX_BURST=2, out_full_n=1:
  - Required: output tag sequence 0,0,1,1,2,2,3,3,0,0 with one bubble between grant changes.
- Backpressure:
  - Stimulus: out_full_n=0 for 5 cycles mid-burst.
  - Required: out_din stable and out_write held; in_full_n all 0 while out_write=1; burst_cnt frozen; no beat lost or duplicated across the stall.
- Early release:
  - Stimulus: requester 1 deasserts in_write after 3 of 8 beats; requester 3 pending.
  - Required: FSM returns to IDLE, requester 3 granted next, rr_ptr=2.
- Reset mid-burst:
  - Stimulus: assert reset asynchronously between clock edges with out_write=1.
  - Required: out_write, in_full_n, grant_valid drop to 0 immediately (before next edge); after release, the first grant goes to the lowest requesting index.
- NUM_REQ=1, MAX_BURST=1:
  - Required: beats alternate accept/bubble; tag always 0; no X on grant_idx.
